mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage pipeline: consumes the EX/MEM register outputs and drives
//  the data-memory bus through a req/ack handshake. Stalls the pipeline while an access
//  is outstanding and resolves branches (pcsrc, target). Registers results into the
//  MEM/WB pipeline register that feeds write-back.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max BUSY cycles awaiting dmem_ack before forced completion
//  CNT_W  $clog2(TIMEOUT_CYCLES+1)  width of the wait counter (derived, do not override)
// PORTS
//  clk                 in   1   single clock, rising edge
//  reset               in   1   asynchronous, active-low reset
//  alu_result_EX_MEM   in   32  ALU result / memory byte address
//  read_data2_EX_MEM   in   32  store data
//  add_alu_out_EX_MEM  in   32  branch target
//  branch_EX_MEM, memread_EX_MEM, memwrite_EX_MEM, memtoreg_EX_MEM, regwrite_EX_MEM
//                      in   1   control bits (one port each)
//  z_flag_EX_MEM       in   1   ALU zero flag
//  rd_EX_MEM           in   5   destination register
//  dmem_req            out  1   request valid; high throughout BUSY
//  dmem_we             out  1   1 = store, 0 = load
//  dmem_addr           out  32  word-aligned address, stable while dmem_req
//  dmem_wdata          out  32  store data, stable while dmem_req
//  dmem_rdata          in   32  load data, valid with dmem_ack
//  dmem_ack            in   1   one-cycle completion pulse
//  pcsrc               out  1   branch taken
//  branch_target       out  32  = add_alu_out_EX_MEM
//  stall_mem           out  1   hold PC, IF/ID, ID/EX, EX/MEM this cycle
//  read_data_MEM_WB    out  32  captured load data
//  alu_result_MEM_WB   out  32  ALU result passthrough
//  memtoreg_MEM_WB, regwrite_MEM_WB  out  1  WB control
//  rd_MEM_WB           out  5   destination register
//  bus_err, misalign_err  out  1  sticky error flags
// BEHAVIOUR
//  - Reset (async, reset==0): state IDLE, counter 0, every output register 0; dmem_req
//    low immediately. Reset mid-BUSY abandons the access; a late ack in IDLE is ignored.
//  - access = memread|memwrite; misaligned = access & alu_result_EX_MEM[1:0]!=0.
//  - FSM {IDLE, BUSY}. IDLE: access & ~misaligned -> latch dmem_addr/we/wdata, go BUSY,
//    counter 0. BUSY: dmem_req=1 (decoded from registered state); ack -> IDLE;
//    counter==TIMEOUT_CYCLES-1 & ~ack -> IDLE, timeout completion.
//  - stall_mem = access & ~misaligned & ~(BUSY & (dmem_ack | timeout)); combinational.
//  - MEM/WB load edge: any non-stalled cycle. While stalled, MEM/WB gets a bubble
//    (regwrite_MEM_WB=0, memtoreg_MEM_WB=0, data unchanged).
//  - Latency: non-memory instr 1 cycle; load/store 1 IDLE + N BUSY cycles, N>=1 (min 2).
//  - Load: read_data_MEM_WB <= dmem_rdata on ack edge. Store: regwrite_MEM_WB <= 0.
//  - Timeout: bus_err set, read_data_MEM_WB <= 0, regwrite_MEM_WB <= 0.
//  - Misaligned: no bus cycle, completes in 1 cycle, misalign_err set, regwrite_MEM_WB<=0.
//  - Sticky flags clear only on reset. dmem_ack while IDLE ignored.
//  - pcsrc = branch_EX_MEM & z_flag_EX_MEM, combinational; never asserted with a memory
//    access (decoder guarantees exclusivity).
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/BUSY) and the default TIMEOUT_CYCLES.
//  - One sub-module dmem_bus_ctrl: FSM, wait counter, bus output registers, done/timeout
//    strobes. Top holds the MEM/WB register, branch logic, stall and error flags.
// TESTING
//  1 Reset low mid-BUSY -> dmem_req drops at once, all outputs 0; ack 2 cycles later ignored.
//  2 ALU op alu_result=0x1234, regwrite=1, rd=5 -> next edge alu_result_MEM_WB=0x1234,
//    rd_MEM_WB=5, regwrite_MEM_WB=1; stall_mem and dmem_req stay 0.
//  3 Load addr 0x40, ack on 3rd BUSY cycle, rdata 0xDEADBEEF -> stall_mem high 3 cycles,
//    dmem_addr=0x40 we=0; bubbles in MEM/WB, then read_data_MEM_WB=0xDEADBEEF,
//    regwrite_MEM_WB=1.
//  4 Store addr 0x80 data 0xCAFEF00D, ack on 1st BUSY cycle -> we=1, wdata=0xCAFEF00D,
//    2-cycle op, regwrite_MEM_WB=0.
//  5 Load, no ack -> forced completion after 16 BUSY cycles, bus_err=1,
//    read_data_MEM_WB=0, regwrite_MEM_WB=0.
//  6 Load addr 0x42 -> no dmem_req, misalign_err=1. Branch with z=1, target 0x100 ->
//    pcsrc=1, branch_target=0x100.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared bus FSM encoding, default timeout and address helpers
package mem_access_stage_pkg;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} bus_state_t;
   localparam int TIMEOUT_CYCLES_DEFAULT = 16;
   function automatic logic is_misaligned(input logic access, input logic [1:0] lsb);
      return access & (lsb != 2'b00);
   endfunction
endpackage

// File: rtl/mem_access_stage_dmem_bus_ctrl.sv
// dmem_bus_ctrl: req/ack bus FSM with wait counter, registered bus outputs and done/timeout strobes
module dmem_bus_ctrl
   import mem_access_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_start,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        dmem_ack,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic        busy,
   output logic        done,
   output logic        timeout
);
   bus_state_t state;
   logic [CNT_W-1:0] cnt;
   assign busy     = state == BUSY;
   assign dmem_req = busy;
   assign done     = busy & dmem_ack;
   assign timeout  = busy & ~dmem_ack & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   // launch an access from IDLE, count BUSY cycles, return on ack or timeout
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
      end else if (state == IDLE) begin
         if (req_start) begin
            state      <= BUSY;
            cnt        <= '0;
            dmem_we    <= req_we;
            dmem_addr  <= {req_addr[31:2], 2'b00};
            dmem_wdata <= req_wdata;
         end
      end else begin
         cnt <= cnt + CNT_W'(1);
         if (done | timeout) state <= IDLE;
      end
   end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage with data-memory handshake, stall, branch resolve and MEM/WB register
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] alu_result_EX_MEM,
   input  logic [31:0] read_data2_EX_MEM,
   input  logic [31:0] add_alu_out_EX_MEM,
   input  logic        branch_EX_MEM,
   input  logic        memread_EX_MEM,
   input  logic        memwrite_EX_MEM,
   input  logic        memtoreg_EX_MEM,
   input  logic        regwrite_EX_MEM,
   input  logic        z_flag_EX_MEM,
   input  logic [4:0]  rd_EX_MEM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        pcsrc,
   output logic [31:0] branch_target,
   output logic        stall_mem,
   output logic [31:0] read_data_MEM_WB,
   output logic [31:0] alu_result_MEM_WB,
   output logic        memtoreg_MEM_WB,
   output logic        regwrite_MEM_WB,
   output logic [4:0]  rd_MEM_WB,
   output logic        bus_err,
   output logic        misalign_err
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic access, misaligned, mem_go, busy, done, timeout;
   assign access        = memread_EX_MEM | memwrite_EX_MEM;
   assign misaligned    = is_misaligned(access, alu_result_EX_MEM[1:0]);
   assign mem_go        = access & ~misaligned;
   assign stall_mem     = mem_go & ~(done | timeout);
   assign pcsrc         = branch_EX_MEM & z_flag_EX_MEM;
   assign branch_target = add_alu_out_EX_MEM;
   dmem_bus_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_bus (
      .clk        (clk),
      .reset      (reset),
      .req_start  (mem_go & ~busy),
      .req_we     (memwrite_EX_MEM),
      .req_addr   (alu_result_EX_MEM),
      .req_wdata  (read_data2_EX_MEM),
      .dmem_ack   (dmem_ack),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout)
   );
   // MEM/WB register: bubble while stalled, otherwise load results; stores, misaligned and timed-out accesses never write back
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         read_data_MEM_WB  <= '0;
         alu_result_MEM_WB <= '0;
         memtoreg_MEM_WB   <= 1'b0;
         regwrite_MEM_WB   <= 1'b0;
         rd_MEM_WB         <= '0;
      end else if (stall_mem) begin
         memtoreg_MEM_WB <= 1'b0;
         regwrite_MEM_WB <= 1'b0;
      end else begin
         alu_result_MEM_WB <= alu_result_EX_MEM;
         rd_MEM_WB         <= rd_EX_MEM;
         memtoreg_MEM_WB   <= memtoreg_EX_MEM;
         regwrite_MEM_WB   <= regwrite_EX_MEM & ~memwrite_EX_MEM & ~misaligned & ~timeout;
         if (timeout) read_data_MEM_WB <= '0;
         else if (done & memread_EX_MEM) read_data_MEM_WB <= dmem_rdata;
      end
   end
   // sticky error flags, cleared only by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus_err      <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         bus_err      <= bus_err | timeout;
         misalign_err <= misalign_err | misaligned;
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for the MEM stage handshake, stall and MEM/WB results
module tb_mem_access_stage;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] alu_result_EX_MEM = '0, read_data2_EX_MEM = '0, add_alu_out_EX_MEM = '0;
   logic        branch_EX_MEM = 0, memread_EX_MEM = 0, memwrite_EX_MEM = 0;
   logic        memtoreg_EX_MEM = 0, regwrite_EX_MEM = 0, z_flag_EX_MEM = 0;
   logic [4:0]  rd_EX_MEM = '0;
   logic        dmem_req, dmem_we, dmem_ack = 0;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
   logic        pcsrc, stall_mem, memtoreg_MEM_WB, regwrite_MEM_WB, bus_err, misalign_err;
   logic [31:0] branch_target, read_data_MEM_WB, alu_result_MEM_WB;
   logic [4:0]  rd_MEM_WB;
   typedef struct {
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        rw;
      logic        mtr;
      logic [31:0] rdata;
      logic        chk_rdata;
   } exp_t;
   exp_t q[$];
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   mem_access_stage dut (
      .clk                (clk),
      .reset              (reset),
      .alu_result_EX_MEM  (alu_result_EX_MEM),
      .read_data2_EX_MEM  (read_data2_EX_MEM),
      .add_alu_out_EX_MEM (add_alu_out_EX_MEM),
      .branch_EX_MEM      (branch_EX_MEM),
      .memread_EX_MEM     (memread_EX_MEM),
      .memwrite_EX_MEM    (memwrite_EX_MEM),
      .memtoreg_EX_MEM    (memtoreg_EX_MEM),
      .regwrite_EX_MEM    (regwrite_EX_MEM),
      .z_flag_EX_MEM      (z_flag_EX_MEM),
      .rd_EX_MEM          (rd_EX_MEM),
      .dmem_req           (dmem_req),
      .dmem_we            (dmem_we),
      .dmem_addr          (dmem_addr),
      .dmem_wdata         (dmem_wdata),
      .dmem_rdata         (dmem_rdata),
      .dmem_ack           (dmem_ack),
      .pcsrc              (pcsrc),
      .branch_target      (branch_target),
      .stall_mem          (stall_mem),
      .read_data_MEM_WB   (read_data_MEM_WB),
      .alu_result_MEM_WB  (alu_result_MEM_WB),
      .memtoreg_MEM_WB    (memtoreg_MEM_WB),
      .regwrite_MEM_WB    (regwrite_MEM_WB),
      .rd_MEM_WB          (rd_MEM_WB),
      .bus_err            (bus_err),
      .misalign_err       (misalign_err)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic check_all_zero(input string tag);
      check({tag, "_req"}, 32'(dmem_req), 0);
      check({tag, "_bus"}, dmem_addr | dmem_wdata | 32'(dmem_we), 0);
      check({tag, "_rdata"}, read_data_MEM_WB, 0);
      check({tag, "_alu"}, alu_result_MEM_WB, 0);
      check({tag, "_ctl"}, {25'b0, rd_MEM_WB, regwrite_MEM_WB, memtoreg_MEM_WB}, 0);
      check({tag, "_err"}, {30'b0, bus_err, misalign_err}, 0);
   endtask
   // drive one instruction, push its expected MEM/WB result, step until it leaves the stage
   task automatic run_instr(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                            input logic mr, input logic mw, input logic mtr, input logic rw,
                            input logic [4:0] rd, input int ack_at, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic exp_rw, input logic chk_rd,
                            input logic [31:0] exp_rd, input int exp_stalls, input int exp_busy);
      exp_t e;
      int bc = 0, st_n = 0;
      logic st, fin = 1'b0;
      @(negedge clk);
      alu_result_EX_MEM = alu; read_data2_EX_MEM = wd;
      memread_EX_MEM = mr; memwrite_EX_MEM = mw; memtoreg_EX_MEM = mtr; regwrite_EX_MEM = rw;
      rd_EX_MEM = rd; branch_EX_MEM = 0; z_flag_EX_MEM = 0;
      q.push_back('{alu, rd, exp_rw, mtr, exp_rd, chk_rd});
      for (int c = 0; c < 40 && !fin; c++) begin
         if (c > 0) @(negedge clk);
         if (dmem_req) bc++;
         dmem_ack = dmem_req && (bc == ack_at);
         dmem_rdata = rdata;
         #1;
         if (dmem_req && bc == 1) begin
            check({tag, "_addr"}, dmem_addr, exp_addr);
            check({tag, "_we"}, 32'(dmem_we), 32'(mw));
            check({tag, "_wdata"}, dmem_wdata, wd);
         end
         st = stall_mem;
         if (st) st_n++;
         @(posedge clk);
         #1;
         if (st) check({tag, "_bubble"}, {30'b0, regwrite_MEM_WB, memtoreg_MEM_WB}, 0);
         else begin
            e = q.pop_front();
            check({tag, "_alu"}, alu_result_MEM_WB, e.alu);
            check({tag, "_rd"}, 32'(rd_MEM_WB), 32'(e.rd));
            check({tag, "_rw"}, 32'(regwrite_MEM_WB), 32'(e.rw));
            check({tag, "_mtr"}, 32'(memtoreg_MEM_WB), 32'(e.mtr));
            if (e.chk_rdata) check({tag, "_rdata"}, read_data_MEM_WB, e.rdata);
            fin = 1'b1;
         end
      end
      dmem_ack = 1'b0;
      check({tag, "_completed"}, 32'(fin), 1);
      check({tag, "_stalls"}, st_n, exp_stalls);
      check({tag, "_busy"}, bc, exp_busy);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b1;
      run_instr("alu", 32'h1234, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 0, 0, 0, 0);
      run_instr("load", 32'h40, 0, 1, 0, 1, 1, 7, 3, 32'hDEADBEEF, 32'h40, 1, 1, 32'hDEADBEEF, 3, 3);
      run_instr("store", 32'h80, 32'hCAFEF00D, 0, 1, 0, 1, 0, 1, 0, 32'h80, 0, 0, 0, 1, 1);
      check("bus_err_clear", 32'(bus_err), 0);
      run_instr("tmo", 32'h44, 0, 1, 0, 1, 1, 9, 0, 32'h5555, 32'h44, 0, 1, 0, 16, 16);
      check("bus_err_set", 32'(bus_err), 1);
      check("misalign_clear", 32'(misalign_err), 0);
      run_instr("mis", 32'h42, 0, 1, 0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
      check("misalign_set", 32'(misalign_err), 1);
      @(negedge clk);
      memread_EX_MEM = 0; memwrite_EX_MEM = 0; regwrite_EX_MEM = 0; memtoreg_EX_MEM = 0;
      branch_EX_MEM = 1; z_flag_EX_MEM = 1; add_alu_out_EX_MEM = 32'h100;
      #1;
      check("br_taken", 32'(pcsrc), 1);
      check("br_target", branch_target, 32'h100);
      check("br_stall", 32'(stall_mem), 0);
      z_flag_EX_MEM = 0;
      #1;
      check("br_not_taken", 32'(pcsrc), 0);
      @(negedge clk);
      branch_EX_MEM = 0;
      alu_result_EX_MEM = 32'h60; memread_EX_MEM = 1; regwrite_EX_MEM = 1; rd_EX_MEM = 3;
      repeat (2) @(posedge clk);
      #2;
      check("rst_pre_req", 32'(dmem_req), 1);
      reset = 1'b0;
      memread_EX_MEM = 0; regwrite_EX_MEM = 0; alu_result_EX_MEM = 0; rd_EX_MEM = 0;
      #1;
      check_all_zero("rst_mid");
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      dmem_ack = 1'b1;
      dmem_rdata = 32'h12345678;
      #1;
      check("late_ack_req", 32'(dmem_req), 0);
      check("late_ack_stall", 32'(stall_mem), 0);
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      check("late_ack_rdata", read_data_MEM_WB, 0);
      check("late_ack_req2", 32'(dmem_req), 0);
      check("late_ack_err", {30'b0, bus_err, misalign_err}, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
